// File: rtl/dispatch_queue.sv
// In-order dispatch buffer between rename and the RS/LSB, with CDB operand wakeup.
// Optional `DISPATCH_QUEUE_BYPASS_EN: an instruction reaching an empty queue issues directly.
module dispatch_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4,
  parameter int OP_W   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_is_lsb,
  input  logic [OP_W-1:0]         in_openum,
  input  logic [DATA_W-1:0]       in_V1,
  input  logic [DATA_W-1:0]       in_V2,
  input  logic [ROB_W-1:0]        in_Q1,
  input  logic [ROB_W-1:0]        in_Q2,
  input  logic [DATA_W-1:0]       in_imm,
  input  logic [DATA_W-1:0]       in_pc,
  input  logic [ROB_W-1:0]        in_rob_id,
  input  logic                    cdb0_valid,
  input  logic [ROB_W-1:0]        cdb0_rob_id,
  input  logic [DATA_W-1:0]       cdb0_result,
  input  logic                    cdb1_valid,
  input  logic [ROB_W-1:0]        cdb1_rob_id,
  input  logic [DATA_W-1:0]       cdb1_result,
  input  logic                    rs_full,
  input  logic                    lsb_full,
  output logic                    ena_to_rs,
  output logic                    ena_to_lsb,
  output logic [OP_W-1:0]         out_openum,
  output logic [DATA_W-1:0]       out_V1,
  output logic [DATA_W-1:0]       out_V2,
  output logic [DATA_W-1:0]       out_imm,
  output logic [DATA_W-1:0]       out_pc,
  output logic [ROB_W-1:0]        out_Q1,
  output logic [ROB_W-1:0]        out_Q2,
  output logic [ROB_W-1:0]        out_rob_id,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              enaRs_q, enaRs_d, enaLsb_q, enaLsb_d;

  logic              memIsLsb_q [DEPTH];
  logic [OP_W-1:0]   memOp_q    [DEPTH];
  logic [DATA_W-1:0] memV1_q    [DEPTH];
  logic [DATA_W-1:0] memV2_q    [DEPTH];
  logic [ROB_W-1:0]  memQ1_q    [DEPTH];
  logic [ROB_W-1:0]  memQ2_q    [DEPTH];
  logic [DATA_W-1:0] memImm_q   [DEPTH];
  logic [DATA_W-1:0] memPc_q    [DEPTH];
  logic [ROB_W-1:0]  memRob_q   [DEPTH];

  logic              doEnq, doDeq, doBypass, issue, issueIsLsb, headDstFull;
  logic [DATA_W-1:0] inV1, inV2, issueV1, issueV2;
  logic [ROB_W-1:0]  inQ1, inQ2, issueQ1, issueQ2;

  // Tag 0 means "ready", so it never matches a broadcast.
  function automatic logic hit0(input logic [ROB_W-1:0] tag);
    return cdb0_valid && (tag != '0) && (tag == cdb0_rob_id);
  endfunction

  function automatic logic hit1(input logic [ROB_W-1:0] tag);
    return cdb1_valid && (tag != '0) && (tag == cdb1_rob_id);
  endfunction

  function automatic logic [DATA_W-1:0] snoopV(input logic [ROB_W-1:0] tag,
                                               input logic [DATA_W-1:0] val);
    if (hit0(tag)) return cdb0_result;
    if (hit1(tag)) return cdb1_result;
    return val;
  endfunction

  function automatic logic [ROB_W-1:0] snoopQ(input logic [ROB_W-1:0] tag);
    return (hit0(tag) || hit1(tag)) ? '0 : tag;
  endfunction

  assign inV1 = snoopV(in_Q1, in_V1);
  assign inV2 = snoopV(in_Q2, in_V2);
  assign inQ1 = snoopQ(in_Q1);
  assign inQ2 = snoopQ(in_Q2);

  assign in_ready    = (count_q < CNT_W'(DEPTH));
  assign headDstFull = memIsLsb_q[head_q] ? lsb_full : rs_full;
  assign doDeq       = rdy && !flush && (count_q != '0) && !headDstFull;

`ifdef DISPATCH_QUEUE_BYPASS_EN
  logic inDstFull;
  assign inDstFull = in_is_lsb ? lsb_full : rs_full;
  assign doBypass  = rdy && !flush && in_valid && (count_q == '0) && !inDstFull;
`else
  assign doBypass  = 1'b0;
`endif

  assign doEnq      = rdy && !flush && in_valid && in_ready && !doBypass;
  assign issue      = doDeq || doBypass;
  assign issueIsLsb = doBypass ? in_is_lsb : memIsLsb_q[head_q];
  assign issueV1    = doBypass ? inV1 : snoopV(memQ1_q[head_q], memV1_q[head_q]);
  assign issueV2    = doBypass ? inV2 : snoopV(memQ2_q[head_q], memV2_q[head_q]);
  assign issueQ1    = doBypass ? inQ1 : snoopQ(memQ1_q[head_q]);
  assign issueQ2    = doBypass ? inQ2 : snoopQ(memQ2_q[head_q]);

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    enaRs_d  = enaRs_q;
    enaLsb_d = enaLsb_q;
    if (rdy) begin
      if (flush) begin
        head_d   = '0;
        tail_d   = '0;
        count_d  = '0;
        enaRs_d  = 1'b0;
        enaLsb_d = 1'b0;
      end else begin
        enaRs_d  = issue && !issueIsLsb;
        enaLsb_d = issue && issueIsLsb;
        if (doEnq) tail_d = tail_q + 1'b1;
        if (doDeq) head_d = head_q + 1'b1;
        count_d = count_q + CNT_W'(doEnq) - CNT_W'(doDeq);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      enaRs_q    <= 1'b0;
      enaLsb_q   <= 1'b0;
      out_openum <= '0;
      out_V1     <= '0;
      out_V2     <= '0;
      out_Q1     <= '0;
      out_Q2     <= '0;
      out_imm    <= '0;
      out_pc     <= '0;
      out_rob_id <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      enaRs_q  <= enaRs_d;
      enaLsb_q <= enaLsb_d;
      if (issue) begin
        out_openum <= doBypass ? in_openum : memOp_q[head_q];
        out_V1     <= issueV1;
        out_V2     <= issueV2;
        out_Q1     <= issueQ1;
        out_Q2     <= issueQ2;
        out_imm    <= doBypass ? in_imm : memImm_q[head_q];
        out_pc     <= doBypass ? in_pc : memPc_q[head_q];
        out_rob_id <= doBypass ? in_rob_id : memRob_q[head_q];
      end
    end
  end

  // Wakeup touches every slot; the enqueue write comes last so it owns the tail slot.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        memV1_q[i] <= snoopV(memQ1_q[i], memV1_q[i]);
        memV2_q[i] <= snoopV(memQ2_q[i], memV2_q[i]);
        memQ1_q[i] <= snoopQ(memQ1_q[i]);
        memQ2_q[i] <= snoopQ(memQ2_q[i]);
      end
      if (doEnq) begin
        memIsLsb_q[tail_q] <= in_is_lsb;
        memOp_q[tail_q]    <= in_openum;
        memV1_q[tail_q]    <= inV1;
        memV2_q[tail_q]    <= inV2;
        memQ1_q[tail_q]    <= inQ1;
        memQ2_q[tail_q]    <= inQ2;
        memImm_q[tail_q]   <= in_imm;
        memPc_q[tail_q]    <= in_pc;
        memRob_q[tail_q]   <= in_rob_id;
      end
    end
  end

  assign ena_to_rs  = enaRs_q;
  assign ena_to_lsb = enaLsb_q;
  assign count      = count_q;

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Parametrised decoded-instruction buffer between the decode/rename stage and the reservation station (RS) and load/store buffer (LSB). It accepts one renamed instruction per cycle with operand values or tags, and holds up to DEPTH entries in order. While entries wait, it snoops both CDBs to wake up pending operands. It issues the head entry to the RS or LSB when that unit is not full, and is flushed on branch misprediction.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- DATA_W, 32, operand/imm/pc width
- ROB_W, 4, ROB tag width; tag 0 means "no dependency"
- OP_W, 6, opcode enum width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes all state, outputs included
- flush  in  1  mispredict flush
- in_valid  in  1  upstream offers an instruction
- in_ready  out  1  queue can accept: count < DEPTH
- in_is_lsb  in  1  destination is LSB (loads/stores), else RS
- in_openum  in  OP_W  opcode
- in_V1, in_V2  in  DATA_W  operand values
- in_Q1, in_Q2  in  ROB_W  operand tags
- in_imm, in_pc  in  DATA_W  immediate, pc
- in_rob_id  in  ROB_W  destination ROB tag
- cdb0_valid, cdb1_valid  in  1  arith / LS CDB broadcast valid
- cdb0_rob_id, cdb1_rob_id  in  ROB_W  broadcast tag
- cdb0_result, cdb1_result  in  DATA_W  broadcast value
- rs_full, lsb_full  in  1  destination cannot accept this cycle
- ena_to_rs, ena_to_lsb  out  1  one-cycle issue pulse
- out_openum  out  OP_W; out_V1, out_V2, out_imm, out_pc  out  DATA_W; out_Q1, out_Q2, out_rob_id  out  ROB_W  issued entry fields
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- The queue is a circular buffer with head and tail pointers of width $clog2(DEPTH). Pointers wrap modulo DEPTH. count disambiguates full from empty.
- Enqueue when in_valid && in_ready && !flush. The entry is written at tail.
- Incoming operands are snooped the same cycle. If in_Qx ≠ 0 and it matches a valid CDB tag, the stored Vx is that CDB result and the stored Qx is 0.
- Every cycle, each occupied entry with Qx ≠ 0 that matches a valid CDB tag gets Vx ← result and Qx ← 0. If both CDBs match the same tag, cdb0 wins.
- Dequeue fires when the queue is not empty and the head's destination is not full: lsb_full when is_lsb, rs_full otherwise.
- On dequeue, the out_* fields register the head, using values snooped this cycle so no wakeup is lost. Exactly one of ena_to_rs or ena_to_lsb pulses high for one cycle, and head advances.
- When no dequeue fires, ena_to_rs and ena_to_lsb are 0 and out_* hold their last values.
- Enqueue and dequeue may occur in the same cycle; count is then unchanged.
- in_ready is 0 when full, even if a dequeue occurs that cycle. There is no full-queue pass-through.
- Flush clears the head, tail and count registers, and forces both ena outputs to 0 next cycle. Flush dominates enqueue and dequeue; entry contents are don't-care.
- Reset behaves like flush, and additionally zeroes all out_* fields. Reset values: count=0, in_ready=1, ena_to_rs=0, ena_to_lsb=0, all out_* 0.
- Reset mid-operation discards all entries.
- rdy=0: no enqueue, dequeue or snoop, and all registers hold. CDB broadcasts during rdy=0 are not captured; the producer also stalls under rdy.
- Priority order: rst > !rdy > flush > normal operation.

## Timing
- Fully synchronous; all outputs are registered except in_ready, which is combinational from count.
- Issue latency without bypass: an instruction enqueued at edge N is issued at edge N+1 at the earliest, so ena is high during cycle N+1.
- Throughput: one issue per cycle while the destination is not full.
- A CDB broadcast at edge N is reflected in an issue at edge N or later.

## Configuration
- DISPATCH_QUEUE_BYPASS_EN defined: bypass applies when the queue is empty, in_valid=1, the destination is not full, and flush=0.
  - The instruction goes straight to out_* with snooped operands at the enqueue edge.
  - Nothing is written and count stays 0.
  - Latency is 0 extra cycles: ena is high the cycle after acceptance.
- DISPATCH_QUEUE_BYPASS_EN undefined: every instruction is written first, giving the minimum latency stated in Timing.

## Test plan
- Reset, then enqueue RS instruction Q1=0,V1=5,Q2=0,V2=7,rob_id=3 with rs_full=0: one ena_to_rs pulse (next cycle with bypass), out_V1=5, out_V2=7, out_rob_id=3, count returns 0.
- Enqueue 4 LSB instructions with lsb_full=1 (DEPTH=4): count=4 and in_ready=0. A fifth in_valid is not accepted. Release lsb_full: 4 consecutive ena_to_lsb pulses in order, and count returns to 0.
- Queue entry Q2=6 held by rs_full=1; cdb1_valid=1, cdb1_rob_id=6, cdb1_result=0xDEAD; release rs_full: issued out_Q2=0, out_V2=0xDEAD.
- In the same cycle, enqueue an entry with in_Q1=9 while cdb0 broadcasts tag 9 with value 0x11: the stored entry issues with Q1=0, V1=0x11.
- Load 3 entries and assert flush together with in_valid: count=0, no ena pulse next cycle, and the flushed entries are never issued.
- Hold rdy=0 for 3 cycles with entries pending and rs_full=0: no ena pulse and count unchanged. Issue resumes the first cycle rdy=1.
